// File: rtl/music_pkg.sv
// Shared note codes, pitch table and half-period helper for the music path.
// Every note ROM and tone stage imports this so codes stay consistent.
package music_pkg;

  localparam logic [4:0] NOTE_S  = 5'd0;
  localparam logic [4:0] NOTE_C4 = 5'd1;
  localparam logic [4:0] NOTE_D4 = 5'd2;
  localparam logic [4:0] NOTE_E4 = 5'd3;
  localparam logic [4:0] NOTE_F4 = 5'd4;
  localparam logic [4:0] NOTE_G4 = 5'd5;
  localparam logic [4:0] NOTE_A4 = 5'd6;
  localparam logic [4:0] NOTE_B4 = 5'd7;
  localparam logic [4:0] NOTE_C5 = 5'd8;

  localparam int unsigned F_C4 = 262;
  localparam int unsigned F_D4 = 294;
  localparam int unsigned F_E4 = 330;
  localparam int unsigned F_F4 = 349;
  localparam int unsigned F_G4 = 392;
  localparam int unsigned F_A4 = 440;
  localparam int unsigned F_B4 = 494;
  localparam int unsigned F_C5 = 523;

  typedef enum logic {ST_IDLE, ST_PLAY} state_t;

  // Half-period in clocks; 0 marks a code with no pitch (silence or invalid).
  function automatic int unsigned half_period(input logic [4:0] code, input int unsigned clk_hz);
    int unsigned f;
    int unsigned h;
    case (code)
      NOTE_C4: f = F_C4;
      NOTE_D4: f = F_D4;
      NOTE_E4: f = F_E4;
      NOTE_F4: f = F_F4;
      NOTE_G4: f = F_G4;
      NOTE_A4: f = F_A4;
      NOTE_B4: f = F_B4;
      NOTE_C5: f = F_C5;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    h = clk_hz / (2 * f);
    return (h < 2) ? 2 : h;
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational note code to half-period lookup; constants fold at elaboration.
// Silence and invalid codes return 0.
module note_period_lut
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic [4:0]       i_code,
  output logic [CNT_W-1:0] o_half
);

  always_comb begin
    o_half = '0;
    case (i_code)
      NOTE_C4: o_half = CNT_W'(half_period(NOTE_C4, CLK_HZ));
      NOTE_D4: o_half = CNT_W'(half_period(NOTE_D4, CLK_HZ));
      NOTE_E4: o_half = CNT_W'(half_period(NOTE_E4, CLK_HZ));
      NOTE_F4: o_half = CNT_W'(half_period(NOTE_F4, CLK_HZ));
      NOTE_G4: o_half = CNT_W'(half_period(NOTE_G4, CLK_HZ));
      NOTE_A4: o_half = CNT_W'(half_period(NOTE_A4, CLK_HZ));
      NOTE_B4: o_half = CNT_W'(half_period(NOTE_B4, CLK_HZ));
      NOTE_C5: o_half = CNT_W'(half_period(NOTE_C5, CLK_HZ));
      default: o_half = '0;
    endcase
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: registered outputs, tone rises 1 cycle after a request.
// Note changes and stops are applied only at half-period boundaries (no runt pulses).
module note_tone_gen
  import music_pkg::*;
#(
  parameter int unsigned        CLK_HZ = 100_000_000,
  parameter logic signed [15:0] AMP    = 16'sd8192,
  parameter int unsigned        CNT_W  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [4:0]         note,
  output logic               tone,
  output logic signed [15:0] sample,
  output logic               playing,
  output logic               note_ack
);

  logic [CNT_W-1:0]   w_in_half;
  logic               w_sound;
  logic               w_same;
  logic               w_boundary;

  state_t             r_state;
  logic [3:0]         r_cur_note;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_half;
  logic               r_phase;
  logic               r_tone;
  logic               r_playing;
  logic               r_ack;
  logic signed [15:0] r_sample;

  note_period_lut #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_lut (
    .i_code (note),
    .o_half (w_in_half)
  );

  // A zero half-period means the code has no pitch, so it counts as silence.
  assign w_sound    = en && (w_in_half != '0);
  assign w_same     = (note[3:0] == r_cur_note);
  assign w_boundary = (r_cnt == (r_half - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_note <= '0;
      r_cnt      <= '0;
      r_half     <= '0;
      r_phase    <= 1'b0;
      r_tone     <= 1'b0;
      r_playing  <= 1'b0;
      r_ack      <= 1'b0;
      r_sample   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_sound) begin
            r_state    <= ST_PLAY;
            r_cur_note <= note[3:0];
            r_half     <= w_in_half;
            r_phase    <= 1'b1;
            r_tone     <= 1'b1;
            r_sample   <= AMP;
            r_playing  <= 1'b1;
            r_ack      <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_boundary) begin
            r_cnt <= '0;
            if (w_sound) begin
              r_phase  <= ~r_phase;
              r_tone   <= ~r_phase;
              r_sample <= r_phase ? -AMP : AMP;
              if (!w_same) begin
                r_cur_note <= note[3:0];
                r_half     <= w_in_half;
                r_ack      <= 1'b1;
              end
            end else begin
              r_state   <= ST_IDLE;
              r_phase   <= 1'b0;
              r_tone    <= 1'b0;
              r_sample  <= '0;
              r_playing <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tone     = r_tone;
  assign sample   = r_sample;
  assign playing  = r_playing;
  assign note_ack = r_ack;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen at CLK_HZ=10480: directed scenarios plus a randomized run
// against a boundary-countdown reference model.
module tb_note_tone_gen;

  localparam int unsigned        CLK_HZ = 10_480;
  localparam logic signed [15:0] AMP    = 16'sd8192;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [4:0]         note;
  logic               tone;
  logic signed [15:0] sample;
  logic               playing;
  logic               note_ack;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining cycles of the current half, not a counter.
  bit m_play;
  bit m_phase;
  int m_note;
  int m_left;
  bit m_ack;

  always #5 clk = ~clk;

  note_tone_gen #(.CLK_HZ(CLK_HZ), .AMP(AMP), .CNT_W(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .note     (note),
    .tone     (tone),
    .sample   (sample),
    .playing  (playing),
    .note_ack (note_ack)
  );

  function automatic int freq_of(input int code);
    case (code)
      1: return 262;
      2: return 294;
      3: return 330;
      4: return 349;
      5: return 392;
      6: return 440;
      7: return 494;
      8: return 523;
      default: return 0;
    endcase
  endfunction

  function automatic int half_of(input int code);
    int h;
    if (freq_of(code) == 0) return 0;
    h = CLK_HZ / (2 * freq_of(code));
    return (h < 2) ? 2 : h;
  endfunction

  function automatic logic signed [15:0] exp_sample(input bit play, input bit hi);
    if (!play) return 16'sd0;
    return hi ? AMP : -AMP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    note = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    m_play = 0; m_phase = 0; m_note = 0; m_left = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input int n);
    bit sound;
    sound = e && (half_of(n) != 0);
    m_ack = 0;
    if (r) begin
      m_play = 0; m_phase = 0; m_note = 0; m_left = 0;
    end else if (!m_play) begin
      if (sound) begin
        m_play = 1; m_phase = 1; m_note = n; m_left = half_of(n); m_ack = 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (sound) begin
          if (n != m_note) begin
            m_note = n;
            m_ack = 1;
          end
          m_phase = !m_phase;
          m_left = half_of(m_note);
        end else begin
          m_play = 0;
          m_phase = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    note = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tone !== 1'b0 || playing !== 1'b0 || note_ack !== 1'b0 || sample !== 16'sd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got tone=%b play=%b ack=%b sample=%0d exp all 0",
                 i, tone, playing, note_ack, sample);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (tone !== 1'b1 || playing !== 1'b1 || note_ack !== 1'b1 || sample !== AMP) begin
      failures++;
      $display("FAIL reset_release_start got tone=%b play=%b ack=%b sample=%0d exp 1 1 1 %0d",
               tone, playing, note_ack, sample, AMP);
    end
    tick();
    checks++;
    if (note_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_single got ack=%b exp 0", note_ack);
    end
  endtask

  task automatic test_steady_c4();
    int acks;
    bit hi;
    do_reset();
    en = 1'b1;
    note = 5'd1;
    acks = 0;
    for (int t = 0; t < 100; t++) begin
      tick();
      hi = ((t / 20) % 2) == 0;
      checks++;
      if (tone !== hi || sample !== exp_sample(1, hi) || playing !== 1'b1) begin
        failures++;
        $display("FAIL steady_c4 t=%0d got tone=%b sample=%0d play=%b exp tone=%b sample=%0d play=1",
                 t, tone, sample, playing, hi, exp_sample(1, hi));
      end
      if (note_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL steady_c4_acks got %0d exp 1", acks);
    end
  endtask

  task automatic test_note_change();
    bit hi;
    bit ack_exp;
    do_reset();
    en = 1'b1;
    note = 5'd8;
    for (int t = 0; t < 70; t++) begin
      tick();
      if (t < 10) hi = 1;
      else if (t < 20) hi = 0;
      else hi = (((t - 20) / 11) % 2) == 0;
      ack_exp = (t == 0) || (t == 20);
      checks++;
      if (tone !== hi || note_ack !== ack_exp) begin
        failures++;
        $display("FAIL note_change t=%0d got tone=%b ack=%b exp tone=%b ack=%b",
                 t, tone, note_ack, hi, ack_exp);
      end
      if (t == 13) note = 5'd6;
    end
  endtask

  task automatic test_stop();
    bit on;
    do_reset();
    en = 1'b1;
    note = 5'd1;
    for (int t = 0; t < 60; t++) begin
      tick();
      on = (t < 20);
      checks++;
      if (tone !== on || playing !== on || sample !== exp_sample(on, 1)) begin
        failures++;
        $display("FAIL stop t=%0d got tone=%b play=%b sample=%0d exp tone=%b play=%b sample=%0d",
                 t, tone, playing, sample, on, on, exp_sample(on, 1));
      end
      if (t == 5) en = 1'b0;
    end
  endtask

  task automatic test_invalid();
    logic [4:0] codes [4];
    codes[0] = 5'd12;
    codes[1] = 5'd0;
    codes[2] = 5'd9;
    codes[3] = 5'd31;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      note = codes[c];
      for (int t = 0; t < 25; t++) begin
        tick();
        checks++;
        if (tone !== 1'b0 || playing !== 1'b0 || note_ack !== 1'b0 || sample !== 16'sd0) begin
          failures++;
          $display("FAIL invalid_code code=%0d t=%0d got tone=%b play=%b ack=%b sample=%0d exp all 0",
                   codes[c], t, tone, playing, note_ack, sample);
        end
      end
    end
    en = 1'b0;
    note = 5'd3;
    for (int t = 0; t < 10; t++) begin
      tick();
      checks++;
      if (playing !== 1'b0 || note_ack !== 1'b0) begin
        failures++;
        $display("FAIL disabled_idle t=%0d got play=%b ack=%b exp 0 0", t, playing, note_ack);
      end
    end
  endtask

  task automatic test_reset_mid_play();
    bit hi;
    do_reset();
    en = 1'b1;
    note = 5'd6;
    for (int t = 0; t < 5; t++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tone !== 1'b0 || playing !== 1'b0 || note_ack !== 1'b0 || sample !== 16'sd0) begin
      failures++;
      $display("FAIL reset_mid_play got tone=%b play=%b ack=%b sample=%0d exp all 0",
               tone, playing, note_ack, sample);
    end
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      hi = ((t / 11) % 2) == 0;
      checks++;
      if (tone !== hi || playing !== 1'b1 || note_ack !== (t == 0)) begin
        failures++;
        $display("FAIL restart_a4 t=%0d got tone=%b play=%b ack=%b exp tone=%b play=1 ack=%b",
                 t, tone, playing, note_ack, hi, (t == 0));
      end
    end
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    en = 1'b1;
    note = 5'd1;
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        if ($urandom_range(0, 5) == 0) note = 5'($urandom_range(0, 31));
        else note = 5'($urandom_range(1, 8));
      end
      if ($urandom_range(0, 40) == 0) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      model_step(rst, en, int'(note));
      tick();
      checks++;
      if (tone !== (m_play && m_phase) || playing !== m_play || note_ack !== m_ack ||
          sample !== exp_sample(m_play, m_phase)) begin
        failures++;
        if (errs < 10)
          $display("FAIL random i=%0d got tone=%b play=%b ack=%b sample=%0d exp tone=%b play=%b ack=%b sample=%0d",
                   i, tone, playing, note_ack, sample, m_play && m_phase, m_play, m_ack,
                   exp_sample(m_play, m_phase));
        errs++;
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady_c4();
    test_note_change();
    test_stop();
    test_invalid();
    test_reset_mid_play();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Downstream audio stage of the pinball music path. Consumes the 5-bit note code produced by the per-song note ROMs (S = silence, C4..C5 = codes 1..8). Produces a glitch-free square wave at the corresponding pitch, both as a 1-bit speaker drive and as a signed sample for the audio DAC path. Note changes are applied only at half-period boundaries, so beat transitions never produce runt pulses.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz; sets every half-period count.
- AMP, 16'sd8192, sample magnitude while playing.
- CNT_W, 20, half-period counter width; must hold CLK_HZ/524.
- clk  input  1  system clock; everything is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  playback enable; 0 means silence.
- note  input  5  note code: 0 = S, 1..8 = C4,D4,E4,F4,G4,A4,B4,C5; 9..31 are treated as S.
- tone  output  1  square-wave speaker drive.
- sample  output  16  signed: +AMP / −AMP while playing, 0 when idle.
- playing  output  1  high in PLAY state.
- note_ack  output  1  one-cycle pulse on each cycle a new note is loaded.

## Operation
- Pitch table, in Hz: C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494, C5 523.
- half(n) = CLK_HZ / (2·f(n)), integer division, truncated. A computed value below 2 is clamped to 2.
- "Sounding" request: en=1 and note in 1..8.
- Registers:
  - cur_note (4 bits)
  - half-period counter cnt (CNT_W bits)
  - phase (1 bit)
  - state
- State IDLE:
  - tone=0, sample=0, playing=0, cnt=0.
  - On a sounding request: load cur_note=note, cnt=0, phase=1, go to PLAY, pulse note_ack.
- State PLAY:
  - tone=phase; sample = phase ? AMP : −AMP; playing=1.
  - Each cycle cnt increments. When cnt == half(cur_note)−1 (the boundary), cnt resets to 0 and the inputs are resampled:
    - Sounding request with note == cur_note: toggle phase.
    - Sounding request with note != cur_note: load the new note, toggle phase, pulse note_ack.
    - Not a sounding request: go to IDLE, set phase=0.
  - Input changes between boundaries are ignored.
- Reset at any time, including mid-half-period: next cycle is IDLE, all outputs 0, cur_note=0, cnt=0, phase=0.
- rst has priority over all inputs.

## Timing
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Start latency: a sounding request sampled on edge k gives tone=1 after edge k. note_ack is high for the same cycle.
- Steady state: each phase lasts exactly half(cur_note) cycles, so the full period is 2·half.
- A new note takes effect at the first boundary after it is presented; the worst case is half(cur_note) cycles.
- Stop: tone falls to 0 at the first boundary after en drops, or after note goes to S or an invalid code.
- A new note equal to cur_note with en held does not pulse note_ack.
- The counter never wraps: the boundary compare always fires before overflow, given the CNT_W constraint.

## Structure
- Shared package `music_pkg`:
  - note code constants S, C4..C5, for reuse by every note ROM and this block;
  - pitch frequency constants;
  - function half_period(code, CLK_HZ).
- One sub-module, `note_period_lut`: combinational code → half-period lookup built from the package function. Invalid codes return 0; the FSM treats 0 as S.
- The top level holds the FSM, the counter and the output registers.

## Test plan
All scenarios use CLK_HZ=10_480, which gives half(C4)=20, half(A4)=11 and half(C5)=10.

- Reset: assert rst for 3 cycles with en=1, note=8 → tone=0, sample=0, playing=0, note_ack=0 throughout; after release the note starts 1 cycle later.
- Steady C4: en=1, note=1 → tone high for 20 cycles, then low for 20, repeating; sample alternates +8192 / −8192; exactly one note_ack.
- Note change mid-half: playing C5, switch to A4 at cycle 4 of a half → the current half still lasts 10 cycles, subsequent halves last 11; note_ack fires at the boundary.
- Stop: drop en mid-half while tone=1 → tone stays 1 until the boundary, then goes to 0 with sample=0 and playing=0; no further toggles.
- Invalid and silence codes: note=12 or note=0 with en=1 from IDLE → stays IDLE, no note_ack.
- Reset mid-play: assert rst at cycle 5 of an A4 half → the next cycle is IDLE with all outputs 0; after release with the request held, the note restarts with a full 11-cycle high phase.
